sync_fifo_flex: RTL



---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ram.sv | 46 ++++
 rtl/sync_fifo_flex.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the single-clock FIFO family.
// Mode encodings, a constant-foldable clog2, and the threshold legality rule.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits++;
    end
    return bits;
  endfunction

  // almost_full must be able to fire before full; almost_empty must be able to clear before full.
  function automatic bit thresholds_legal(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth - 1) && (aempty >= 0) && (aempty <= depth - 2);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DATA_WIDTH x 2**PTR_WIDTH storage, synchronous write, read port either
// registered with enable (standard FIFO) or asynchronous (first-word-fall-through).
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 4,
  parameter bit ASYNC_READ = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [PTR_WIDTH-1:0]  w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  input  logic [PTR_WIDTH-1:0]  r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 2 ** PTR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; emptiness is tracked by the pointers, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  if (ASYNC_READ) begin : g_async_read
    logic unused_read_ctrl;
    assign unused_read_ctrl = rst ^ r_en;
    assign r_data = mem[r_addr];
  end else begin : g_sync_read
    logic [DATA_WIDTH-1:0] r_data_q;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data_q <= '0;
      end else if (r_en) begin
        r_data_q <= mem[r_addr];
      end
    end
    assign r_data = r_data_q;
  end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with standard or FWFT read, occupancy count,
// programmable almost-full/almost-empty and sticky overflow/underflow flags.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int PTR_WIDTH     = 4,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  if ((DEPTH != 2 ** PTR_WIDTH) || (clog2(DEPTH) != PTR_WIDTH)) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must equal 2**PTR_WIDTH");
  end
  if (!thresholds_legal(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_flex: almost-full/almost-empty threshold out of range");
  end
  if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_mode
    $error("sync_fifo_flex: FWFT must be 0 or 1");
  end

  localparam logic [PTR_WIDTH:0] DEPTH_C  = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AFULL_C  = (PTR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [PTR_WIDTH:0] AEMPTY_C = (PTR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH:0]    count_q;
  logic [PTR_WIDTH:0]    count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Acceptance uses the registered flags, so a full FIFO rejects writes even alongside a read.
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  // NOTE: count_nxt gets a default before the case so no latch is inferred.
  always_comb begin
    count_nxt = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
    end
  end

  // Flags come from the next-state count so they line up with count in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
    end
  end

  // Set has priority over err_clr so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

  assign count = count_q;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH),
    .ASYNC_READ (FWFT == FIFO_MODE_FWFT)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .w_en   (wr_acc),
    .w_addr (wr_ptr),
    .w_data (data_in),
    .r_en   (rd_acc),
    .r_addr (rd_ptr),
    .r_data (ram_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft_out
    assign data_out = empty ? '0 : ram_rdata;
  end else begin : g_std_out
    assign data_out = ram_rdata;
  end

endmodule
